// File: rtl/bcd_seg_mux.sv
// bcd_seg_mux -- two-digit multiplexed 7-segment driver.
//
// Captures a BCD tens/ones pair on load and time-multiplexes it onto a
// common segment bus. Each digit is lit for REFRESH_DIV cycles, with a
// one-cycle all-off gap between digits so the segment bus never changes
// while an anode is enabled. Refresh period is 2*REFRESH_DIV+2 cycles.
//
// Ports
//   clk       sole clock, rising edge
//   reset     synchronous active-high reset (overrides load/clr)
//   load      single-cycle strobe, captures n2/n1
//   clr       synchronous clear of captured value, back to blank
//   n2, n1    tens / ones digit in BCD
//   blank_lz  suppress a tens digit of 0 (live input, not captured)
//   seg[6:0]  active-low segments a..g
//   an[1:0]   active-low digit enables, an[0]=ones, an[1]=tens
//   valid     a captured value is being displayed
//   err       a captured digit is outside 0..9
module bcd_seg_mux #(
   parameter int REFRESH_DIV = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic       clr,
   input  logic [3:0] n2,
   input  logic [3:0] n1,
   input  logic       blank_lz,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       valid,
   output logic       err
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ONES = 3'd1,
      GAP1 = 3'd2,
      TENS = 3'd3,
      GAP0 = 3'd4
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [3:0]    d2, d1;

   function automatic logic [6:0] seg7(input logic [3:0] v);
      case (v)
         4'd0:    seg7 = 7'b0000001;
         4'd1:    seg7 = 7'b1001111;
         4'd2:    seg7 = 7'b0010010;
         4'd3:    seg7 = 7'b0000110;
         4'd4:    seg7 = 7'b1001100;
         4'd5:    seg7 = 7'b0100100;
         4'd6:    seg7 = 7'b0100000;
         4'd7:    seg7 = 7'b0001111;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0000100;
         default: seg7 = 7'b1111110; // dash for non-BCD
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         d2    <= '0;
         d1    <= '0;
      end else if (clr) begin
         state <= IDLE;
         cnt   <= '0;
         d2    <= '0;
         d1    <= '0;
      end else begin
         // Capture is independent of state: a load mid-refresh just swaps
         // the displayed value without disturbing the slot timing.
         if (load) begin
            d2 <= n2;
            d1 <= n1;
         end
         case (state)
            IDLE: begin
               cnt <= '0;
               if (load) state <= ONES;
            end
            ONES: begin
               if (cnt == LAST) begin
                  state <= GAP1;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            GAP1: begin
               state <= TENS;
               cnt   <= '0;
            end
            TENS: begin
               if (cnt == LAST) begin
                  state <= GAP0;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            GAP0: begin
               state <= ONES;
               cnt   <= '0;
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Moore decode from registered state and digits; blank_lz is live.
   always_comb begin
      an    = 2'b11;
      seg   = 7'b1111111;
      valid = (state != IDLE);
      err   = valid & ((d2 > 4'd9) | (d1 > 4'd9));
      case (state)
         ONES: begin
            an  = 2'b10;
            seg = seg7(d1);
         end
         TENS: begin
            if (!(blank_lz && d2 == 4'd0)) begin
               an  = 2'b01;
               seg = seg7(d2);
            end
         end
         default: begin
            an  = 2'b11;
            seg = 7'b1111111;
         end
      endcase
   end

endmodule

// File: tb/tb_bcd_seg_mux.sv
// Scoreboard bench for bcd_seg_mux with REFRESH_DIV=4. The driver pushes
// the hand-computed expected outputs for each cycle; a monitor on the
// falling edge pops and compares.
module tb_bcd_seg_mux;

   logic       clk = 1'b0;
   logic       reset, load, clr, blank_lz;
   logic [3:0] n2, n1;
   logic [6:0] seg;
   logic [1:0] an;
   logic       valid, err;

   typedef struct packed {
      logic [1:0] an;
      logic [6:0] seg;
      logic       valid;
      logic       err;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   localparam logic [6:0] OFF  = 7'b1111111;
   localparam logic [6:0] S0   = 7'b0000001;
   localparam logic [6:0] S1   = 7'b1001111;
   localparam logic [6:0] S2   = 7'b0010010;
   localparam logic [6:0] S3   = 7'b0000110;
   localparam logic [6:0] S4   = 7'b1001100;
   localparam logic [6:0] S5   = 7'b0100100;
   localparam logic [6:0] S7   = 7'b0001111;
   localparam logic [6:0] DASH = 7'b1111110;

   bcd_seg_mux #(.REFRESH_DIV(4)) dut (
      .clk(clk), .reset(reset), .load(load), .clr(clr),
      .n2(n2), .n1(n1), .blank_lz(blank_lz),
      .seg(seg), .an(an), .valid(valid), .err(err)
   );

   always #5 clk = ~clk;

   // Monitor: outputs are presented every cycle, sampled mid-cycle.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e, a;
         e = sb.pop_front();
         a = '{an: an, seg: seg, valid: valid, err: err};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL out_chk #%0d: got an=%b seg=%b valid=%b err=%b, want an=%b seg=%b valid=%b err=%b",
                     checks, a.an, a.seg, a.valid, a.err, e.an, e.seg, e.valid, e.err);
         end
      end
   end

   // Push expectation for the current cycle, then advance one edge.
   // Inputs set before the call act on the next edge (blank_lz at once).
   task automatic chk(input logic [1:0] a, input logic [6:0] s,
                      input logic v, input logic e);
      sb.push_back('{an: a, seg: s, valid: v, err: e});
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) chk(2'b11, OFF, 1'b0, 1'b0);
   endtask

   // One full refresh period starting at the first ONES cycle.
   task automatic period(input logic [1:0] oa, input logic [6:0] os,
                         input logic [1:0] ta, input logic [6:0] ts,
                         input logic e);
      for (int i = 0; i < 4; i++) chk(oa, os, 1'b1, e);
      chk(2'b11, OFF, 1'b1, e);
      for (int i = 0; i < 4; i++) chk(ta, ts, 1'b1, e);
      chk(2'b11, OFF, 1'b1, e);
   endtask

   task automatic do_load(input logic [3:0] t, input logic [3:0] o);
      n2 = t; n1 = o; load = 1'b1;
      chk(2'b11, OFF, 1'b0, 1'b0);
      load = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; load = 1'b0; clr = 1'b0; blank_lz = 1'b0;
      n2 = 4'd0; n1 = 4'd0;
      @(posedge clk); #1;

      // Reset state, then no load for 10 cycles.
      idle(2);
      reset = 1'b0;
      idle(10);

      // 15: repeating 10-cycle pattern.
      do_load(4'd1, 4'd5);
      period(2'b10, S5, 2'b01, S1, 1'b0);
      period(2'b10, S5, 2'b01, S1, 1'b0);

      // Clear from ONES, then 07 with leading-zero blanking on and off.
      clr = 1'b1;
      chk(2'b10, S5, 1'b1, 1'b0);
      clr = 1'b0;
      idle(1);
      blank_lz = 1'b1;
      do_load(4'd0, 4'd7);
      period(2'b10, S7, 2'b11, OFF, 1'b0);
      blank_lz = 1'b0;
      period(2'b10, S7, 2'b01, S0, 1'b0);

      // Non-BCD tens digit.
      clr = 1'b1;
      chk(2'b10, S7, 1'b1, 1'b0);
      clr = 1'b0;
      do_load(4'd12, 4'd3);
      period(2'b10, S3, 2'b01, DASH, 1'b1);

      // Load mid-refresh: slot timing continues, value swaps next cycle.
      n2 = 4'd4; n1 = 4'd2; load = 1'b1;
      chk(2'b10, S3, 1'b1, 1'b1);
      load = 1'b0;
      for (int i = 0; i < 3; i++) chk(2'b10, S2, 1'b1, 1'b0);
      chk(2'b11, OFF, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) chk(2'b01, S4, 1'b1, 1'b0);
      chk(2'b11, OFF, 1'b1, 1'b0);

      // clr and load together in TENS: clr wins.
      for (int i = 0; i < 4; i++) chk(2'b10, S2, 1'b1, 1'b0);
      chk(2'b11, OFF, 1'b1, 1'b0);
      clr = 1'b1; load = 1'b1; n2 = 4'd9; n1 = 4'd9;
      chk(2'b01, S4, 1'b1, 1'b0);
      clr = 1'b0; load = 1'b0;
      idle(3);

      // Reset (with load) in the 2nd ONES cycle, then a clean restart.
      do_load(4'd1, 4'd5);
      chk(2'b10, S5, 1'b1, 1'b0);
      reset = 1'b1; load = 1'b1; n2 = 4'd8; n1 = 4'd8;
      chk(2'b10, S5, 1'b1, 1'b0);
      reset = 1'b0; load = 1'b0;
      idle(2);
      do_load(4'd1, 4'd5);
      period(2'b10, S5, 2'b01, S1, 1'b0);

      @(negedge clk); #1;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
